// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard sequencer.
//               - state_e     : sequencer states (RUN, MD_BUSY)
//               - c_MAX_LAT   : largest supported MUL/DIV occupancy of EX
//               - c_CNT_W     : width of the MUL/DIV countdown counter
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  localparam int c_MAX_LAT = 16;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detector. Flags when the
//               instruction in ID reads the destination of a load in EX.
//               A load targeting x0 never creates a hazard.
// Ports       : id_rs1, id_rs2         - ID source register indices
//               id_use_rs1, id_use_rs2 - ID instruction really reads source
//               ex_mem_read            - EX instruction is a load
//               ex_rd                  - EX destination register
//               hazard                 - 1 when a bubble is required
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard    = ex_mem_read && (ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage pipeline.
//               Resolves redirects, MUL/DIV occupancy of EX and load-use
//               hazards, and counts cycles in which the PC is held.
// Ports       : clk, rst (async, active-low)
//               id_rs1/id_rs2/id_use_rs1/id_use_rs2 - ID source info
//               ex_mem_read/ex_rd                   - EX load info
//               ex_redirect                         - taken branch/jump in EX
//               ex_md_start/ex_md_is_div            - MUL/DIV op held in EX
//               pc_en, *_en                         - pipeline register enables
//               if_id_flush/id_ex_flush/ex_mem_flush - bubble inserts
//               md_done                             - MUL/DIV result valid pulse
//               stall_count                         - cycles with pc_en low
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_redirect,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_done,
  output logic [31:0] stall_count
);

  // The counter holds the number of stall cycles still to come after the
  // current one, so a start cycle loads LAT-2.
  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 2);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT - 2);

  state_e             state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]        stall_count_q;
  logic               w_lu_hazard;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (w_lu_hazard)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_done      = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_md_start) begin
          // Freeze the front of the pipe; the op ahead drains to WB while
          // EX/MEM receives bubbles.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_d        = ex_md_is_div ? c_DIV_LOAD : c_MUL_LOAD;
          state_d      = MD_BUSY;
        end else if (w_lu_hazard) begin
          // The load itself moves on; ID holds and EX gets a bubble.
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
          cnt_d        = cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Reset forces every control low immediately, independent of the clock.
    if (!rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      md_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign stall_count = stall_count_q;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: directed vector
//               table, hand-written multi-cycle sequences and a randomized run
//               compared against a cycle-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read;
  logic        ex_redirect, ex_md_start, ex_md_is_div;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, md_done;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .md_done      (md_done),
    .stall_count  (stall_count)
  );

  // Output vector: {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,
  //                 if_id_flush,id_ex_flush,ex_mem_flush,md_done}
  localparam logic [8:0] O_RUN   = 9'b11111_000_0;
  localparam logic [8:0] O_REDIR = 9'b11111_110_0;
  localparam logic [8:0] O_LU    = 9'b00111_010_0;
  localparam logic [8:0] O_STALL = 9'b00011_001_0;
  localparam logic [8:0] O_DONE  = 9'b11111_000_1;
  localparam logic [8:0] O_RESET = 9'b00000_000_0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles elapsed since a MUL/DIV started (-1 = none).
  int          md_age = -1;
  int          md_lat = 0;
  logic [31:0] m_sc   = 32'd0;

  function automatic logic [8:0] outs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush, ex_mem_flush, md_done};
  endfunction

  function automatic logic [8:0] model_out();
    logic lu;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (md_age >= 0) return (md_age < md_lat - 1) ? O_STALL : O_DONE;
    if (ex_redirect) return O_REDIR;
    if (ex_md_start) return O_STALL;
    if (lu)          return O_LU;
    return O_RUN;
  endfunction

  task automatic model_advance();
    logic [8:0] o;
    o = model_out();
    if (!o[8]) m_sc = m_sc + 32'd1;
    if (md_age >= 0) begin
      if (md_age == md_lat - 1) md_age = -1;
      else md_age = md_age + 1;
    end else if (!ex_redirect && ex_md_start) begin
      md_lat = ex_md_is_div ? 16 : 3;
      md_age = 1;
    end
  endtask

  task automatic chk_o(input string nm, input logic [8:0] exp);
    n_cmp++;
    if (outs() !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs got %b want %b at %0t", nm, outs(), exp, $time);
    end
  endtask

  task automatic chk_sc(input string nm, input logic [31:0] exp);
    n_cmp++;
    if (stall_count !== exp) begin
      n_bad++;
      $display("FAIL %s: stall_count got %h want %h at %0t", nm, stall_count, exp, $time);
    end
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle_exp(input string nm, input logic [8:0] exp);
    @(negedge clk);
    chk_o(nm, exp);
    chk_sc(nm, m_sc);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_in(input logic redir, input logic mds, input logic div,
                        input logic mrd, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    ex_redirect = redir; ex_md_start = mds; ex_md_is_div = div;
    ex_mem_read = mrd;   ex_rd = rd;       id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1  = u1;    id_use_rs2 = u2;
  endtask

  typedef struct {
    logic       redir, mds, div, mrd;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] sc0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, O_RUN};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  5'd1, 5'd5, 1'b1, 1'b1, O_LU};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0, 5'd0, 1'b1, 1'b1, O_RUN};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  5'd7, 5'd2, 1'b1, 1'b0, O_LU};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  5'd7, 5'd7, 1'b0, 1'b0, O_RUN};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd9,  5'd9, 5'd9, 1'b1, 1'b1, O_RUN};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, O_REDIR};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  5'd3, 5'd0, 1'b1, 1'b0, O_REDIR};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  5'd5, 5'd6, 1'b1, 1'b1, O_RUN};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd0, 5'd31, 1'b0, 1'b1, O_LU};

    // Reset state
    rst = 1'b0;
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_o("reset_outs", O_RESET);
    chk_sc("reset_sc", 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed table, each vector one cycle from RUN
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].redir, vecs[i].mds, vecs[i].div, vecs[i].mrd, vecs[i].rd,
             vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2);
      cycle_exp($sformatf("vec%0d", i), vecs[i].exp);
    end
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle_exp("after_table", O_RUN);

    // Load-use costs one cycle, count goes up by exactly one
    sc0 = m_sc;
    set_in(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    cycle_exp("lu_single", O_LU);
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle_exp("lu_after", O_RUN);
    chk_sc("lu_count", sc0 + 32'd1);

    // DIV at default latency: 15 stalls, done in 16th cycle, no retrigger
    sc0 = m_sc;
    set_in(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 16; i++)
      cycle_exp($sformatf("div_c%0d", i), (i < 15) ? O_STALL : O_DONE);
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle_exp("div_after", O_RUN);
    chk_sc("div_count", sc0 + 32'd15);

    // MUL: 2 stalls, done in cycle 3; hazards ignored while busy
    sc0 = m_sc;
    set_in(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle_exp("mul_c0", O_STALL);
    set_in(1, 1, 0, 1, 5'd6, 5'd6, 5'd6, 1, 1);
    cycle_exp("mul_c1", O_STALL);
    cycle_exp("mul_c2", O_DONE);
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle_exp("mul_after", O_RUN);
    chk_sc("mul_count", sc0 + 32'd2);

    // Reset four cycles into a DIV
    set_in(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 4; i++) cycle_exp($sformatf("rdiv_c%0d", i), O_STALL);
    rst = 1'b0;
    #1;
    chk_o("midrst_outs", O_RESET);
    chk_sc("midrst_sc", 32'd0);
    md_age = -1; m_sc = 32'd0;
    @(posedge clk); #1;
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    rst = 1'b1;
    cycle_exp("post_rst", O_RUN);
    cycle_exp("post_rst2", O_RUN);

    // Counter wrap
    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count_q;
    m_sc = 32'hFFFF_FFFF;
    set_in(0, 0, 0, 1, 5'd12, 5'd12, 5'd0, 1, 0);
    cycle_exp("wrap_lu", O_LU);
    set_in(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    cycle_exp("wrap_after", O_RUN);
    chk_sc("wrap_zero", 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if (md_age < 0) begin
        ex_md_start  = ($urandom_range(0, 5) == 0);
        ex_md_is_div = ($urandom_range(0, 3) == 0);
      end
      ex_redirect = ($urandom_range(0, 4) == 0);
      ex_mem_read = $urandom_range(0, 1) == 1;
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1) == 1;
      id_use_rs2  = $urandom_range(0, 1) == 1;
      cycle_exp("rand", model_out());
      // The op leaves EX after its done cycle
      if (md_age < 0 && ex_md_start && !ex_redirect) ex_md_start = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32IM pipeline. Drives the `enable` and `flush` inputs of every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves three hazard classes:
- load-use stalls;
- taken-branch/jump redirects;
- multi-cycle MUL/DIV occupancy of EX.

It also keeps a stall-cycle performance counter. It sits beside the datapath in the processor top level. All decisions are combinational from current state plus inputs, so they act on the same clock edge.

## Interface
Parameters
- `MUL_LAT`, default 3: total cycles a MUL-class op occupies EX. Legal range 2..16.
- `DIV_LAT`, default 16: total cycles a DIV/REM op occupies EX. Legal range 2..16.

Ports
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads that source.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `ex_md_start`  in  1  valid MUL/DIV op in EX; held high for as long as the op stays in EX.
- `ex_md_is_div`  in  1  selects `DIV_LAT` (1) or `MUL_LAT` (0).
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  register enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  NOP-insert flushes.
- `md_done`  out  1  one-cycle pulse: MUL/DIV result is valid this cycle.
- `stall_count`  out  32  count of cycles with `pc_en`=0.

## Operation
- Default in state RUN with no hazard: all enables 1, all flushes 0.
- State machine has two states, RUN and MD_BUSY.
- The countdown counter is `cnt`, width $clog2(16).

Priority in RUN, highest first:
1. **Redirect** (`ex_redirect`=1): `if_id_flush`=1, `id_ex_flush`=1, all enables 1. `ex_md_start` is ignored this cycle.
2. **MUL/DIV start** (`ex_md_start`=1): `pc_en`, `if_id_en`, `id_ex_en` = 0; `ex_mem_flush`=1; `mem_wb_en`=1. Load `cnt` with LAT-2, where LAT is selected by `ex_md_is_div`. Next state is MD_BUSY.
3. **Load-use**: fires when `ex_mem_read`=1, `ex_rd`≠0, and (`id_use_rs1`=1 with `id_rs1`=`ex_rd`, or `id_use_rs2`=1 with `id_rs2`=`ex_rd`). Response: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 (bubble). Lasts one cycle only, because the load advances.

MD_BUSY:
- While `cnt`≠0: stall exactly as in a start cycle and decrement `cnt`.
- When `cnt`=0: release cycle. All enables 1, `md_done`=1, next state RUN.
- `ex_redirect` and load-use are ignored in MD_BUSY. The MUL/DIV op is in EX, so neither can legally occur.
- `ex_md_start` is ignored in MD_BUSY, so the release cycle cannot retrigger.

`stall_count`:
- Increments on every post-reset cycle in which `pc_en`=0.
- Wraps from 0xFFFF_FFFF to 0.

While `rst`=0:
- All enables 0, all flushes 0, `md_done`=0.
- State RUN, `cnt`=0, `stall_count`=0.

Reset asserted mid-MD_BUSY aborts the operation immediately. After release, the block is in RUN with no pending stall.

## Timing
- Hazard outputs are combinational, valid in the same cycle as their inputs. They take effect on the next rising edge.
- A MUL/DIV with latency LAT starting in cycle T gives:
  - stalls in T .. T+LAT-2 (LAT-1 stall cycles);
  - `md_done` in cycle T+LAT-1;
  - next instruction enters EX at T+LAT.
- A LAT=2 op stalls only in cycle T and releases in T+1.
- Load-use costs exactly one bubble cycle. A load whose `ex_rd`=x0 never stalls.
- `stall_count` updates on the edge that ends the stalled cycle, so it is visible one cycle later.

## Structure
Shared package `pipeline_ctrl_pkg` holds:
- the state enum {RUN, MD_BUSY};
- localparams for maximum latency (16) and counter width.

Sub-module `load_use_detect` is purely combinational. It takes the ID sources, use flags, `ex_mem_read` and `ex_rd`, and outputs a 1-bit `hazard`.

Top-level RTL holds the FSM, the countdown, the priority mux and `stall_count`.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 → one cycle of `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; `stall_count` 0→1.
- **x0 load:** same as above but `ex_rd`=0 → no stall; all enables 1.
- **Redirect over MUL/DIV:** `ex_redirect`=1 together with `ex_md_start`=1 → `if_id_flush`=1 and `id_ex_flush`=1; no stall; state stays RUN.
- **DIV, default latency:** `ex_md_start`=1, `ex_md_is_div`=1 held → 15 stall cycles with `ex_mem_flush`=1, `md_done` in the 16th cycle, `stall_count`=15, no retrigger. MUL repeats this with 2 stalls and `md_done` in cycle 3.
- **Reset mid-operation:** pull `rst` low 4 cycles into a DIV → outputs go to the reset values immediately. After release: RUN, all enables 1, `stall_count`=0.
- **Counter wrap:** force `stall_count`=0xFFFF_FFFF, then one load-use stall → `stall_count` reads 0.
